counter_updown_n: RTL and testbench

- Parametrised up/down counter; successor to the fixed 16-bit increment-only counter.
- Adds configurable width and modulus, decrement, synchronous load and clear, wrap or saturate mode, and selectable edge/level event qualification.
- Feeds the 7-segment display driver. It is cascadable as decimal digits: MAX_COUNT=9, and wrap_up/wrap_dn drive the next digit's inc/dec.
- inc/dec come from the debouncer outputs or from push buttons.

---
 rtl/counter_updown_n.sv | 107 ++++++++++
 tb/tb_counter_updown_n.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_n.sv
// Parametrised up/down counter with modulus, wrap/saturate ends, synchronous
// clear/load and edge- or level-qualified count requests. Wrap pulses let
// instances cascade as digits (wrap_up/wrap_dn drive the next digit's inc/dec).
module counter_updown_n #(
    parameter int unsigned     WIDTH     = 16,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE  = 1'b0,
    parameter bit              EDGE_MODE = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap_up,
    output logic             wrap_dn
);

    localparam logic [WIDTH-1:0] MAX_V = MAX_COUNT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic             inc_q;
    logic             dec_q;
    logic             up_ev;
    logic             dn_ev;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_up_nxt;
    logic             wrap_dn_nxt;

    // Request history for edge detection; resets high so a level held across
    // reset release is not mistaken for a fresh edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inc_q <= 1'b1;
            dec_q <= 1'b1;
        end else begin
            inc_q <= inc;
            dec_q <= dec;
        end
    end

    // Qualify requests as rising edges or as levels.
    always_comb begin
        up_ev = inc;
        dn_ev = dec;
        if (EDGE_MODE) begin
            up_ev = inc & ~inc_q;
            dn_ev = dec & ~dec_q;
        end
    end

    // Next count: clear beats load beats a single count event; ends are
    // compared explicitly against MAX_V so non-power-of-2 moduli are exact.
    always_comb begin
        count_nxt   = count;
        wrap_up_nxt = 1'b0;
        wrap_dn_nxt = 1'b0;
        if (clr) begin
            count_nxt = '0;
        end else if (load) begin
            count_nxt = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (up_ev && !dn_ev) begin
            if (count >= MAX_V) begin
                if (!SATURATE) begin
                    count_nxt   = '0;
                    wrap_up_nxt = 1'b1;
                end
            end else begin
                count_nxt = count + ONE_V;
            end
        end else if (dn_ev && !up_ev) begin
            if (count == '0) begin
                if (!SATURATE) begin
                    count_nxt   = MAX_V;
                    wrap_dn_nxt = 1'b1;
                end
            end else begin
                count_nxt = count - ONE_V;
            end
        end
    end

    // Count and wrap pulses are registered together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            wrap_up <= 1'b0;
            wrap_dn <= 1'b0;
        end else begin
            count   <= count_nxt;
            wrap_up <= wrap_up_nxt;
            wrap_dn <= wrap_dn_nxt;
        end
    end

    // End-of-range flags decoded straight from the count register.
    always_comb begin
        at_max = (count == MAX_V);
        at_min = (count == '0);
    end

endmodule

// File: tb/tb_counter_updown_n.sv
// Bench for counter_updown_n: four differently parameterised instances share
// one stimulus stream and are scored against an arithmetic reference model;
// a two-digit decimal cascade is checked against plain base-10 arithmetic.
module tb_counter_updown_n;

    typedef struct packed {
        logic [31:0] cnt;
        logic [3:0]  flags;   // {wrap_up, wrap_dn, at_max, at_min}
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        inc, dec, clr, load, casc_inc;
    logic [15:0] load_val;

    logic [15:0] a_count; logic a_max, a_min, a_wu, a_wd;
    logic [3:0]  b_count; logic b_max, b_min, b_wu, b_wd;
    logic [3:0]  c_count; logic c_max, c_min, c_wu, c_wd;
    logic [2:0]  d_count; logic d_max, d_min, d_wu, d_wd;
    logic [3:0]  lo_count; logic lo_max, lo_min, lo_wu, lo_wd;
    logic [3:0]  hi_count; logic hi_max, hi_min, hi_wu, hi_wd;

    // a: defaults (16-bit, wrap, edge)
    counter_updown_n u_a (
        .clk(clk), .reset_n(reset_n), .inc(inc), .dec(dec), .clr(clr), .load(load),
        .load_val(load_val), .count(a_count), .at_max(a_max), .at_min(a_min),
        .wrap_up(a_wu), .wrap_dn(a_wd));

    // b: decimal digit, wrap, level
    counter_updown_n #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0), .EDGE_MODE(0)) u_b (
        .clk(clk), .reset_n(reset_n), .inc(inc), .dec(dec), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .count(b_count), .at_max(b_max), .at_min(b_min),
        .wrap_up(b_wu), .wrap_dn(b_wd));

    // c: decimal digit, saturate, level
    counter_updown_n #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1), .EDGE_MODE(0)) u_c (
        .clk(clk), .reset_n(reset_n), .inc(inc), .dec(dec), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .count(c_count), .at_max(c_max), .at_min(c_min),
        .wrap_up(c_wu), .wrap_dn(c_wd));

    // d: modulus 6 in 3 bits, saturate, edge
    counter_updown_n #(.WIDTH(3), .MAX_COUNT(5), .SATURATE(1), .EDGE_MODE(1)) u_d (
        .clk(clk), .reset_n(reset_n), .inc(inc), .dec(dec), .clr(clr), .load(load),
        .load_val(load_val[2:0]), .count(d_count), .at_max(d_max), .at_min(d_min),
        .wrap_up(d_wu), .wrap_dn(d_wd));

    // two-digit decimal cascade
    counter_updown_n #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0), .EDGE_MODE(1)) u_lo (
        .clk(clk), .reset_n(reset_n), .inc(casc_inc), .dec(1'b0), .clr(1'b0), .load(1'b0),
        .load_val(4'd0), .count(lo_count), .at_max(lo_max), .at_min(lo_min),
        .wrap_up(lo_wu), .wrap_dn(lo_wd));

    counter_updown_n #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0), .EDGE_MODE(0)) u_hi (
        .clk(clk), .reset_n(reset_n), .inc(lo_wu), .dec(1'b0), .clr(1'b0), .load(1'b0),
        .load_val(4'd0), .count(hi_count), .at_max(hi_max), .at_min(hi_min),
        .wrap_up(hi_wu), .wrap_dn(hi_wd));

    int n_total = 0;
    int n_pass  = 0;
    int hi_wraps = 0;

    // reference model state and per-instance parameters
    longint unsigned pmax [4] = '{65535, 9, 9, 5};
    longint unsigned pmask[4] = '{65535, 15, 15, 7};
    bit              psat [4] = '{0, 0, 1, 1};
    bit              pedge[4] = '{1, 0, 0, 1};
    longint unsigned mcnt [4];
    bit              mincq[4];
    bit              mdecq[4];
    exp_t            expq [4][$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mcnt[k]  = 0;
            mincq[k] = 1'b1;
            mdecq[k] = 1'b1;
        end
    endtask

    // One clock of behaviour for instance k, written from the rules:
    // clear, else clamped load, else a lone up/down step with wrap or saturate.
    task automatic model_push(input int k, input bit i, input bit d, input bit c,
                              input bit l, input logic [15:0] lv);
        bit up, dn, wu, wd;
        longint unsigned lvk;
        exp_t e;
        up = pedge[k] ? (i && !mincq[k]) : i;
        dn = pedge[k] ? (d && !mdecq[k]) : d;
        mincq[k] = i;
        mdecq[k] = d;
        wu = 0;
        wd = 0;
        lvk = longint'(lv) & pmask[k];
        if (c) mcnt[k] = 0;
        else if (l) mcnt[k] = (lvk > pmax[k]) ? pmax[k] : lvk;
        else if (up && !dn) begin
            if (mcnt[k] == pmax[k]) begin
                if (!psat[k]) begin mcnt[k] = 0; wu = 1; end
            end else mcnt[k] = mcnt[k] + 1;
        end else if (dn && !up) begin
            if (mcnt[k] == 0) begin
                if (!psat[k]) begin mcnt[k] = pmax[k]; wd = 1; end
            end else mcnt[k] = mcnt[k] - 1;
        end
        e.cnt   = 32'(mcnt[k]);
        e.flags = {wu, wd, mcnt[k] == pmax[k], mcnt[k] == 0};
        expq[k].push_back(e);
    endtask

    function automatic exp_t observe(input int k);
        exp_t o;
        o = '0;
        case (k)
            0: begin o.cnt = 32'(a_count); o.flags = {a_wu, a_wd, a_max, a_min}; end
            1: begin o.cnt = 32'(b_count); o.flags = {b_wu, b_wd, b_max, b_min}; end
            2: begin o.cnt = 32'(c_count); o.flags = {c_wu, c_wd, c_max, c_min}; end
            3: begin o.cnt = 32'(d_count); o.flags = {d_wu, d_wd, d_max, d_min}; end
            default: ;
        endcase
        return o;
    endfunction

    // Monitor: each registered update is compared with the oldest expectation.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 4; k++) begin
            if (expq[k].size() > 0) begin
                exp_t e, o;
                e = expq[k].pop_front();
                o = observe(k);
                chk($sformatf("sb%0d_count", k), longint'(o.cnt), longint'(e.cnt));
                chk($sformatf("sb%0d_flags", k), longint'(o.flags), longint'(e.flags));
            end
        end
    end

    always @(negedge clk) if (hi_wu) hi_wraps++;

    task automatic cyc(input bit i, input bit d, input bit c, input bit l,
                       input logic [15:0] lv, input bit ci);
        @(negedge clk);
        inc = i; dec = d; clr = c; load = l; load_val = lv; casc_inc = ci;
        if (reset_n)
            for (int k = 0; k < 4; k++) model_push(k, i, d, c, l, lv);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int snap;
        int edges;
        reset_n = 1'b0;
        inc = 0; dec = 0; clr = 0; load = 0; load_val = '0; casc_inc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_count", longint'(a_count), 0);
        chk("rst_at_min", longint'(a_min), 1);
        chk("rst_at_max", longint'(a_max), 0);
        chk("rst_wrap", longint'({a_wu, a_wd}), 0);
        #1 reset_n = 1'b1;

        // five rising inc edges, then inc held
        for (int j = 0; j < 5; j++) begin
            cyc(1, 0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0, 0);
        end
        repeat (4) cyc(1, 0, 0, 0, 0, 0);
        settle();
        chk("edge_five", longint'(a_count), 5);
        chk("level_nine", longint'(b_count), 9);
        cyc(0, 0, 0, 0, 0, 0);

        // decimal wrap up then wrap down
        cyc(0, 0, 1, 0, 0, 0);
        for (int j = 1; j <= 10; j++) begin
            cyc(1, 0, 0, 0, 0, 0);
            settle();
            chk($sformatf("dec_up_%0d", j), longint'(b_count), j % 10);
            chk($sformatf("dec_wu_%0d", j), longint'(b_wu), (j == 10) ? 1 : 0);
        end
        cyc(0, 1, 0, 0, 0, 0);
        settle();
        chk("dec_dn_count", longint'(b_count), 9);
        chk("dec_dn_wd", longint'(b_wd), 1);

        // saturation at both ends
        cyc(0, 0, 0, 1, 16'd9, 0);
        repeat (3) cyc(1, 0, 0, 0, 0, 0);
        settle();
        chk("sat_hi_count", longint'(c_count), 9);
        chk("sat_hi_flags", longint'({c_wu, c_max}), 1);
        cyc(0, 0, 1, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0, 0);
        settle();
        chk("sat_lo_count", longint'(c_count), 0);
        chk("sat_lo_flags", longint'({c_wd, c_min}), 1);

        // priority
        cyc(0, 0, 0, 1, 16'd5, 0);
        cyc(1, 0, 1, 1, 16'd3, 0);
        settle();
        chk("pri_clr", longint'(b_count), 0);
        cyc(0, 1, 0, 1, 16'd7, 0);
        settle();
        chk("pri_load_dec", longint'(b_count), 7);
        cyc(0, 0, 0, 1, 16'd12, 0);
        settle();
        chk("pri_clamp", longint'(b_count), 9);
        cyc(0, 0, 0, 1, 16'd4, 0);
        cyc(1, 1, 0, 0, 0, 0);
        settle();
        chk("pri_both_b", longint'(b_count), 4);
        chk("pri_both_a", longint'(a_count), 4);
        cyc(0, 0, 0, 0, 0, 0);

        // asynchronous reset between clocks, inc held through release
        cyc(0, 0, 0, 1, 16'h1234, 0);
        settle();
        chk("pre_rst", longint'(a_count), 32'h1234);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_count", longint'(a_count), 0);
        chk("async_rst_flags", longint'({a_wu, a_wd, a_max, a_min}), 1);
        model_reset();
        @(negedge clk) inc = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (3) cyc(1, 0, 0, 0, 0, 0);
        settle();
        chk("held_inc", longint'(a_count), 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        settle();
        chk("re_edge", longint'(a_count), 1);

        // decimal cascade
        snap  = hi_wraps;
        edges = 0;
        for (int n = 0; n < 100; n++) begin
            cyc(0, 0, 0, 0, 0, 1);
            cyc(0, 0, 0, 0, 0, 0);
            edges++;
        end
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        settle();
        chk("casc100_lo", longint'(lo_count), edges % 10);
        chk("casc100_hi", longint'(hi_count), (edges / 10) % 10);
        chk("casc100_hiwrap", longint'(hi_wraps - snap), 1);
        for (int n = 0; n < 37; n++) begin
            cyc(0, 0, 0, 0, 0, 1);
            cyc(0, 0, 0, 0, 0, 0);
            edges++;
        end
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        settle();
        chk("casc137_lo", longint'(lo_count), 7);
        chk("casc137_hi", longint'(hi_count), 3);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [15:0] lv;
            case ($urandom_range(0, 3))
                0: lv = 16'hFFFF;
                1: lv = 16'hFFFE;
                default: lv = 16'($urandom);
            endcase
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 24) == 0), ($urandom_range(0, 9) == 0), lv, 0);
        end
        cyc(0, 0, 0, 0, 0, 0);
        settle();
        for (int k = 0; k < 4; k++)
            chk($sformatf("sb%0d_drain", k), longint'(expq[k].size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
